// File: rtl/pc_redirect_unit_pkg.sv
// Shared PC-stage definitions: reset vector, FSM states and next-PC select codes.
// Imported by the PC stage, controller and hazard unit.
package pc_redirect_unit_pkg;

    localparam logic [31:0] PC_RESET = 32'h0040_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_redirect_unit_next_pc_calc.sv
// Combinational next-PC target generation and redirect priority select.
// Priority: JR/JALR over J/JAL over conditional branch; otherwise sequential.
module pc_redirect_unit_next_pc_calc
    import pc_redirect_unit_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_bu_out,
    input  logic        i_jump,
    input  logic        i_jump_reg,
    input  logic [31:0] i_id_pc,
    input  logic [31:0] i_imm_ext,
    input  logic [25:0] i_jump_index,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_pc_add,
    output logic [31:0] o_link,
    output logic [31:0] o_target,
    output logic        o_redirect
);

    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_jr_tgt;
    pc_sel_e     w_sel;

    assign o_pc_add = i_pc + PC_STEP;
    assign o_link   = i_id_pc + PC_STEP;
    assign w_br_tgt = o_link + (i_imm_ext << 2);
    assign w_j_tgt  = {o_link[31:28], i_jump_index, 2'b00};
    assign w_jr_tgt = word_align(i_jr_target);

    always_comb begin
        w_sel = SEL_SEQ;
        if (i_jump_reg) begin
            w_sel = SEL_JR;
        end else if (i_jump) begin
            w_sel = SEL_J;
        end else if (i_bu_out) begin
            w_sel = SEL_BR;
        end
    end

    always_comb begin
        o_target = o_pc_add;
        unique case (w_sel)
            SEL_JR:  o_target = w_jr_tgt;
            SEL_J:   o_target = w_j_tgt;
            SEL_BR:  o_target = w_br_tgt;
            SEL_SEQ: o_target = o_pc_add;
        endcase
    end

    assign o_redirect = (w_sel != SEL_SEQ);

endmodule

// File: rtl/pc_redirect_unit.sv
// PC stage: owns the fetch PC, squashes IF/ID on redirects and defers
// redirects that arrive under a hazard stall until the stall releases.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             BU_out,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      imm_ext,
    input  logic [25:0]      jump_index,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_add_out,
    output logic [31:0]      link_addr,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] redirect_cnt
);

    pc_state_e        r_state;
    pc_state_e        w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      r_pend;
    logic [31:0]      w_pend_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_inc;
    logic             w_flush;
    logic [31:0]      w_target;
    logic             w_redirect;

    pc_redirect_unit_next_pc_calc u_next_pc_calc (
        .i_pc         (r_pc),
        .i_bu_out     (BU_out),
        .i_jump       (jump),
        .i_jump_reg   (jump_reg),
        .i_id_pc      (id_pc),
        .i_imm_ext    (imm_ext),
        .i_jump_index (jump_index),
        .i_jr_target  (jr_target),
        .o_pc_add     (pc_add_out),
        .o_link       (link_addr),
        .o_target     (w_target),
        .o_redirect   (w_redirect)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_cnt_inc   = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    w_pc_nxt  = w_target;
                    w_flush   = w_redirect;
                    w_cnt_inc = w_redirect;
                end else if (w_redirect) begin
                    w_pend_nxt  = w_target;
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // ID still holds the same branch while stalled, so inputs are ignored here
                if (!stall) begin
                    w_pc_nxt    = r_pend;
                    w_flush     = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_pend  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pc           = r_pc;
    assign flush_ifid   = w_flush && !rst;
    assign redirect_cnt = r_cnt;

endmodule
